// File: rtl/complete_stage_pkg.sv
// Shared completion-stage types and sizing.
// FU result and PRF write packet layouts.
package sys_defs;

    localparam int NUM_FU     = 10;
    localparam int NUM_LANES  = 7;
    localparam int PRF_IDX_W  = 6;
    localparam int ROB_IDX_W  = 5;
    localparam int PTR_W      = $clog2(NUM_FU);
    localparam int LANE_CNT_W = $clog2(NUM_LANES + 1);

    typedef struct packed {
        logic [PRF_IDX_W-1:0] idx;
        logic [31:0]          value;
        logic [ROB_IDX_W-1:0] rob_idx;
    } FU_RESULT_PACKET;

    typedef struct packed {
        logic [PRF_IDX_W-1:0] idx;
        logic [31:0]          value;
    } FU_PRF_PACKET;

    // Modular add on the round-robin pointer; n is below NUM_FU.
    function automatic logic [PTR_W-1:0] ptr_add(
        input logic [PTR_W-1:0] p,
        input int               n
    );
        int s;
        s = int'(p) + n;
        if (s >= NUM_FU) s = s - NUM_FU;
        return PTR_W'(s);
    endfunction

endpackage

// File: rtl/complete_stage_arbiter.sv
// Round-robin arbiter granting up to NUM_LANES requests.
// The k-th grant in scan order is routed to lane k.
module rr_multi_arbiter
    import sys_defs::*;
(
    input  logic [NUM_FU-1:0]                 req,
    input  logic [PTR_W-1:0]                  start,
    output logic [NUM_FU-1:0]                 grant,
    output logic [NUM_LANES-1:0][NUM_FU-1:0]  lane_sel,
    output logic [PTR_W-1:0]                  next_ptr
);

    // Scan from start, grant the first occupied slots, track last grant.
    always_comb begin
        logic [LANE_CNT_W-1:0] cnt;
        logic [PTR_W-1:0]      pos;
        grant    = '0;
        lane_sel = '0;
        next_ptr = start;
        cnt      = '0;
        pos      = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            pos = ptr_add(start, j);
            if (req[pos] && cnt < LANE_CNT_W'(NUM_LANES)) begin
                grant[pos]         = 1'b1;
                lane_sel[cnt][pos] = 1'b1;
                next_ptr           = ptr_add(pos, 1);
                cnt                = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/complete_stage.sv
// Completion stage: per-FU holding slots feeding PRF write lanes.
// Slots are drained round-robin; squash flushes everything pending.
module complete_stage
    import sys_defs::*;
(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 squash,
    input  logic [NUM_FU-1:0]                    fu_valid,
    input  FU_RESULT_PACKET [NUM_FU-1:0]         fu_packet,
    output logic [NUM_FU-1:0]                    fu_ready,
    output FU_PRF_PACKET [NUM_LANES-1:0]         prf_fu_in,
    output logic [NUM_LANES-1:0]                 cdb_valid,
    output logic [NUM_LANES-1:0][ROB_IDX_W-1:0]  cdb_rob_idx
);

    logic [NUM_FU-1:0]                occupied;
    FU_RESULT_PACKET [NUM_FU-1:0]     slot;
    logic [PTR_W-1:0]                 rr_ptr;
    logic [NUM_FU-1:0]                granted;
    logic [NUM_LANES-1:0][NUM_FU-1:0] lane_sel;
    logic [PTR_W-1:0]                 next_ptr;

    rr_multi_arbiter u_arb (
        .req      (occupied),
        .start    (rr_ptr),
        .grant    (granted),
        .lane_sel (lane_sel),
        .next_ptr (next_ptr)
    );

    assign fu_ready = ~occupied | granted;

    // Slot capture/drain and pointer advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            occupied <= '0;
            slot     <= '0;
            rr_ptr   <= '0;
        end else if (squash) begin
            occupied <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    occupied[i] <= 1'b1;
                    slot[i]     <= fu_packet[i];
                end else if (granted[i]) begin
                    occupied[i] <= 1'b0;
                end
            end
            rr_ptr <= next_ptr;
        end
    end

    // Route granted slots onto lanes; squash suppresses all writes.
    always_comb begin
        prf_fu_in   = '0;
        cdb_valid   = '0;
        cdb_rob_idx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (lane_sel[k][i]) begin
                    prf_fu_in[k].idx   = slot[i].idx;
                    prf_fu_in[k].value = slot[i].value;
                    cdb_rob_idx[k]     = slot[i].rob_idx;
                    cdb_valid[k]       = 1'b1;
                end
            end
            if (squash) begin
                cdb_valid[k]     = 1'b0;
                prf_fu_in[k].idx = '0;
            end
        end
    end

endmodule

// File: tb/tb_complete_stage.sv
// Directed bench for complete_stage.
// Hand-computed expectations checked with immediate assertions.
module tb_complete_stage;
    import sys_defs::*;

    logic                                clock;
    logic                                reset;
    logic                                squash;
    logic [NUM_FU-1:0]                   fu_valid;
    FU_RESULT_PACKET [NUM_FU-1:0]        fu_packet;
    logic [NUM_FU-1:0]                   fu_ready;
    FU_PRF_PACKET [NUM_LANES-1:0]        prf_fu_in;
    logic [NUM_LANES-1:0]                cdb_valid;
    logic [NUM_LANES-1:0][ROB_IDX_W-1:0] cdb_rob_idx;

    int checks = 0;
    int errors = 0;

    complete_stage dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .fu_valid    (fu_valid),
        .fu_packet   (fu_packet),
        .fu_ready    (fu_ready),
        .prf_fu_in   (prf_fu_in),
        .cdb_valid   (cdb_valid),
        .cdb_rob_idx (cdb_rob_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < NUM_FU; i++) begin
            fu_packet[i] = {6'(i + 1), 32'(100 + i), 5'(i)};
        end
        fu_valid = '1;
    endtask

    int grants [NUM_FU];
    int last_g [NUM_FU];
    int max_gap [NUM_FU];
    int total;

    initial begin
        reset     = 1'b1;
        squash    = 1'b0;
        fu_valid  = '0;
        fu_packet = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_ready", 64'(fu_ready), 64'h3FF);
        chk("rst_cdb", 64'(cdb_valid), 64'h0);
        for (int k = 0; k < NUM_LANES; k++) begin
            chk($sformatf("rst_lane%0d", k), 64'(prf_fu_in[k]), 64'h0);
            chk($sformatf("rst_rob%0d", k), 64'(cdb_rob_idx[k]), 64'h0);
        end

        // single result from FU3
        fu_valid[3]  = 1'b1;
        fu_packet[3] = {6'd5, 32'hDEAD_BEEF, 5'd7};
        step();
        fu_valid = '0;
        #1;
        chk("one_idx", 64'(prf_fu_in[0].idx), 64'd5);
        chk("one_val", 64'(prf_fu_in[0].value), 64'hDEADBEEF);
        chk("one_cdb", 64'(cdb_valid), 64'b0000001);
        chk("one_rob", 64'(cdb_rob_idx[0]), 64'd7);
        chk("one_ready", 64'(fu_ready), 64'h3FF);
        step();
        chk("one_idle_cdb", 64'(cdb_valid), 64'h0);
        chk("one_idle_idx", 64'(prf_fu_in[0].idx), 64'h0);
        chk("one_ptr", 64'(dut.rr_ptr), 64'd4);

        // over-subscription from rr_ptr=0
        reset = 1'b1;
        step();
        reset = 1'b0;
        load_all();
        step();
        fu_valid = '0;
        #1;
        chk("os1_cdb", 64'(cdb_valid), 64'h7F);
        chk("os1_ready", 64'(fu_ready), 64'h07F);
        for (int k = 0; k < NUM_LANES; k++) begin
            chk($sformatf("os1_idx%0d", k), 64'(prf_fu_in[k].idx), 64'(k + 1));
            chk($sformatf("os1_val%0d", k), 64'(prf_fu_in[k].value),
                64'(100 + k));
        end
        step();
        chk("os2_cdb", 64'(cdb_valid), 64'b0000111);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("os2_idx%0d", k), 64'(prf_fu_in[k].idx), 64'(k + 8));
            chk($sformatf("os2_rob%0d", k), 64'(cdb_rob_idx[k]), 64'(k + 7));
        end
        chk("os2_idx3", 64'(prf_fu_in[3].idx), 64'h0);
        step();
        chk("os_ptr", 64'(dut.rr_ptr), 64'd0);
        chk("os_idle", 64'(cdb_valid), 64'h0);

        // back-to-back refill on FU0
        fu_valid[0]  = 1'b1;
        fu_packet[0] = {6'd3, 32'd1, 5'd1};
        step();
        for (int v = 1; v <= 3; v++) begin
            if (v < 3) fu_packet[0] = {6'd3, 32'(v + 1), 5'd1};
            else fu_valid = '0;
            #1;
            chk($sformatf("b2b_val%0d", v), 64'(prf_fu_in[0].value), 64'(v));
            chk($sformatf("b2b_cdb%0d", v), 64'(cdb_valid), 64'b1);
            chk($sformatf("b2b_rdy%0d", v), 64'(fu_ready[0]), 64'b1);
            step();
        end
        chk("b2b_idle", 64'(cdb_valid), 64'h0);

        // squash with all ten pending
        load_all();
        step();
        fu_valid = '0;
        squash   = 1'b1;
        #1;
        chk("sq_cdb", 64'(cdb_valid), 64'h0);
        for (int k = 0; k < NUM_LANES; k++) begin
            chk($sformatf("sq_idx%0d", k), 64'(prf_fu_in[k].idx), 64'h0);
        end
        step();
        squash = 1'b0;
        #1;
        chk("sq_ready", 64'(fu_ready), 64'h3FF);
        chk("sq_after_cdb", 64'(cdb_valid), 64'h0);
        chk("sq_ptr", 64'(dut.rr_ptr), 64'd1);

        // fairness under continuous load
        for (int i = 0; i < NUM_FU; i++) begin
            grants[i]  = 0;
            last_g[i]  = -1;
            max_gap[i] = 0;
        end
        total = 0;
        load_all();
        step();
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (cdb_valid[k]) begin
                    int f;
                    f = int'(cdb_rob_idx[k]);
                    if (f < NUM_FU) begin
                        grants[f]++;
                        if (c - last_g[f] > max_gap[f]) max_gap[f] = c - last_g[f];
                        last_g[f] = c;
                    end
                    total++;
                end
            end
            step();
        end
        fu_valid = '0;
        chk("fair_total", 64'(total), 64'd70);
        for (int i = 0; i < NUM_FU; i++) begin
            chk($sformatf("fair_g%0d", i), 64'(grants[i]), 64'd7);
            checks++;
            assert (max_gap[i] <= 2) else begin
                errors++;
                $error("FAIL fair_gap%0d got %0d want <=2", i, max_gap[i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
